fetch_control: RTL and testbench

//   Sequencing controller for the instruction-fetch stage and the IF/ID pipeline register.

---
 rtl/fetch_control_pkg.sv | 16 +
 rtl/fetch_control_sat_counter.sv | 33 +++
 rtl/fetch_control.sv | 137 +++++++++++++
 tb/tb_fetch_control.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fetch_control_pkg.sv
// Shared types for the fetch sequencing controller and the ID-side hazard logic.
// No logic here, so there is no latency.
// No flow control; these are types and constants only.
package fetch_ctrl_pkg;

  localparam int STATE_W = 2;
  localparam int RA_W    = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_control_sat_counter.sv
// Saturating event counter used for performance debug.
// The count shows an increment one cycle after inc is sampled.
// No backpressure: the count holds at all-ones and never wraps.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Next count: clear wins; otherwise step up unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register; the synchronous clear doubles as the reset.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_control.sv
// Fetch-stage sequencer: PC enable/select and IF/ID write/flush from state, hazards and redirects.
// Controls are combinational with a same-cycle effect; state and counters update on the next edge.
// Load-use stalls hold PC and IF/ID; a MEM redirect always wins over a stall or a halt.
module fetch_control #(
  parameter int BOOT_CYCLES  = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int RA_W         = fetch_ctrl_pkg::RA_W,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread_ex,
  input  logic [RA_W-1:0]  rd_ex,
  input  logic [RA_W-1:0]  rs1_id,
  input  logic [RA_W-1:0]  rs2_id,
  input  logic             uses_rs2_id,
  input  logic             branch_taken_mem,
  input  logic             halt_id,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  import fetch_ctrl_pkg::*;

  // Boot and drain share one down-counter; it must hold the larger preload.
  localparam int SEQ_MAX = (BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES;
  localparam int SEQ_W   = (SEQ_MAX <= 4) ? 2 : $clog2(SEQ_MAX);
  localparam logic [SEQ_W-1:0] BOOT_INIT  = SEQ_W'(BOOT_CYCLES - 1);
  localparam logic [SEQ_W-1:0] DRAIN_INIT = SEQ_W'(DRAIN_CYCLES - 1);
  localparam logic [SEQ_W-1:0] SEQ_ONE    = SEQ_W'(1);

  fetch_state_e     state_d, state_q;
  logic [SEQ_W-1:0] seq_d, seq_q;
  logic             load_use;
  logic             stall_inc;
  logic             flush_inc;

  // Load in EX feeding a register that the ID instruction actually reads; x0 never stalls.
  always_comb begin
    load_use = memread_ex && (rd_ex != '0) &&
               ((rd_ex == rs1_id) || (uses_rs2_id && (rd_ex == rs2_id)));
  end

  // Per-state controls and next state; anything a state does not drive stays 0.
  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    halted      = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (seq_q == '0) state_d = ST_RUN;
        else             seq_d   = seq_q - SEQ_ONE;
      end
      ST_RUN: begin
        if (branch_taken_mem) begin
          // Redirect squashes the wrong-path instructions in IF, ID and EX.
          pc_src      = 1'b1;
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          exmem_flush = 1'b1;
          flush_inc   = 1'b1;
        end else if (load_use) begin
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
        end else if (halt_id) begin
          // The halt itself moves on as a NOP while older instructions drain.
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          state_d    = ST_DRAIN;
          seq_d      = DRAIN_INIT;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end
      ST_DRAIN: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (seq_q == '0) state_d = ST_HALTED;
        else             seq_d   = seq_q - SEQ_ONE;
      end
      ST_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_BOOT;
        seq_d   = BOOT_INIT;
      end
    endcase
  end

  // State and sequence-counter registers with synchronous reset into boot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      seq_q   <= BOOT_INIT;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_fetch_control.sv
// Bench for fetch_control: directed scenarios followed by random traffic against a timeline model.
// Outputs are compared mid-cycle, half a period before the edge that consumes the inputs.
// A narrow-counter copy shares the stimulus so saturation is reached in few cycles.
module tb_fetch_control;

  localparam int BOOT_CYCLES  = 2;
  localparam int DRAIN_CYCLES = 3;
  localparam int RA_W         = 5;
  localparam int SAT_W        = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            memread_ex;
  logic [RA_W-1:0] rd_ex, rs1_id, rs2_id;
  logic            uses_rs2_id, branch_taken_mem, halt_id;

  logic        pc_write, pc_src, ifid_write, ifid_flush, idex_bubble, exmem_flush, halted;
  logic [31:0] stall_count, flush_count;
  logic        s_pc_write, s_pc_src, s_ifid_write, s_ifid_flush, s_idex_bubble, s_exmem_flush, s_halted;
  logic [SAT_W-1:0] s_stall_count, s_flush_count;

  int checks = 0;
  int failures = 0;

  // Model: cycles since reset, cycle at which the halt was accepted, raw event totals.
  int     cyc;
  int     halt_at;
  longint stall_n;
  longint flush_n;

  always #5 clk = ~clk;

  fetch_control #(.BOOT_CYCLES(BOOT_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES), .RA_W(RA_W), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .memread_ex(memread_ex), .rd_ex(rd_ex), .rs1_id(rs1_id),
    .rs2_id(rs2_id), .uses_rs2_id(uses_rs2_id), .branch_taken_mem(branch_taken_mem),
    .halt_id(halt_id), .pc_write(pc_write), .pc_src(pc_src), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
    .halted(halted), .stall_count(stall_count), .flush_count(flush_count));

  fetch_control #(.BOOT_CYCLES(BOOT_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES), .RA_W(RA_W), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .reset(reset), .memread_ex(memread_ex), .rd_ex(rd_ex), .rs1_id(rs1_id),
    .rs2_id(rs2_id), .uses_rs2_id(uses_rs2_id), .branch_taken_mem(branch_taken_mem),
    .halt_id(halt_id), .pc_write(s_pc_write), .pc_src(s_pc_src), .ifid_write(s_ifid_write),
    .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .exmem_flush(s_exmem_flush),
    .halted(s_halted), .stall_count(s_stall_count), .flush_count(s_flush_count));

  function automatic longint sat(input longint n, input int w);
    longint top;
    top = (longint'(1) << w) - 1;
    return (n > top) ? top : n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle();
    memread_ex = 0; rd_ex = '0; rs1_id = '0; rs2_id = '0;
    uses_rs2_id = 0; branch_taken_mem = 0; halt_id = 0;
  endtask

  // One clock: compare mid-cycle against the model, advance the model, cross the edge.
  task automatic step(input bit do_check);
    logic [6:0] exp_ctl;
    bit lu, br, hz;
    #4;
    lu = memread_ex && (rd_ex != 0) && ((rd_ex == rs1_id) || (uses_rs2_id && (rd_ex == rs2_id)));
    br = 0; hz = 0;
    // exp_ctl = {pc_write, pc_src, ifid_write, ifid_flush, idex_bubble, exmem_flush, halted}
    if (cyc < BOOT_CYCLES)                 exp_ctl = 7'b0011100;
    else if (halt_at >= 0 && cyc - halt_at <= DRAIN_CYCLES) exp_ctl = 7'b0001100;
    else if (halt_at >= 0)                 exp_ctl = 7'b0000001;
    else if (branch_taken_mem) begin       exp_ctl = 7'b1111110; br = 1; end
    else if (lu)                           exp_ctl = 7'b0000100;
    else if (halt_id) begin                exp_ctl = 7'b0011000; hz = 1; end
    else                                   exp_ctl = 7'b1010000;
    if (do_check) begin
      chk("controls", 64'({pc_write, pc_src, ifid_write, ifid_flush, idex_bubble, exmem_flush, halted}), 64'(exp_ctl));
      chk("controls_narrow", 64'({s_pc_write, s_pc_src, s_ifid_write, s_ifid_flush, s_idex_bubble, s_exmem_flush, s_halted}), 64'(exp_ctl));
      chk("stall_count", 64'(stall_count), 64'(sat(stall_n, 32)));
      chk("flush_count", 64'(flush_count), 64'(sat(flush_n, 32)));
      chk("stall_count_sat", 64'(s_stall_count), 64'(sat(stall_n, SAT_W)));
      chk("flush_count_sat", 64'(s_flush_count), 64'(sat(flush_n, SAT_W)));
    end
    if (reset) begin
      cyc = 0; halt_at = -1; stall_n = 0; flush_n = 0;
    end else begin
      if (cyc >= BOOT_CYCLES && halt_at < 0) begin
        if (br)      flush_n++;
        else if (lu) stall_n++;
        else if (hz) halt_at = cyc;
      end
      cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc = 0; halt_at = -1; stall_n = 0; flush_n = 0;
    idle();
    reset = 1;
    step(0);
    reset = 0;

    // Boot: two held cycles (inputs ignored, even a redirect plus hazard), then run.
    step(1);
    branch_taken_mem = 1; memread_ex = 1; rd_ex = 5; rs1_id = 5;
    step(1);
    idle();
    step(1);

    // Load-use on rs1, then rd=0 which never stalls.
    memread_ex = 1; rd_ex = 5; rs1_id = 5;
    step(1);
    idle(); step(1);
    memread_ex = 1; rd_ex = 0; rs1_id = 0;
    step(1);

    // rs2 match only counts when the ID instruction reads rs2.
    memread_ex = 1; rd_ex = 7; rs1_id = 1; rs2_id = 7; uses_rs2_id = 0;
    step(1);
    uses_rs2_id = 1;
    step(1);

    // Redirect wins over a simultaneous load-use.
    branch_taken_mem = 1;
    step(1);
    idle(); step(1);

    // Halt, drain (redirect ignored), halted.
    halt_id = 1;
    step(1);
    idle(); branch_taken_mem = 1;
    repeat (4) step(1);
    halt_id = 1; memread_ex = 1; rd_ex = 3; rs1_id = 3;
    repeat (2) step(1);

    // Reset from halted, then reset again mid-drain.
    idle(); reset = 1; step(1); reset = 0;
    repeat (3) step(1);
    halt_id = 1; step(1);
    idle(); step(1);
    reset = 1; step(1); reset = 0;
    repeat (3) step(1);

    // Long stall run drives the narrow counter into saturation.
    memread_ex = 1; rd_ex = 9; rs1_id = 9;
    repeat (10) step(1);
    idle(); step(1);

    // Random traffic with small register indices so hazards are common.
    for (int i = 0; i < 800; i++) begin
      reset            = ($urandom_range(0, 79) == 0);
      memread_ex       = ($urandom_range(0, 2) == 0);
      rd_ex            = RA_W'($urandom_range(0, 3));
      rs1_id           = RA_W'($urandom_range(0, 3));
      rs2_id           = RA_W'($urandom_range(0, 3));
      uses_rs2_id      = 1'($urandom_range(0, 1));
      branch_taken_mem = ($urandom_range(0, 7) == 0);
      halt_id          = ($urandom_range(0, 24) == 0);
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
